// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: recovers signed step position and direction from a 4-phase one-hot coil bus.
// Defining STALL_DETECT_EN builds a stall detector for the TRACK state; otherwise stall is tied low.
`timescale 1ns/1ps
module stepper_phase_decoder #(
   parameter int POS_W     = 16,
   parameter int FILT_CYC  = 4,
   parameter int STALL_CYC = 10000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       phase_in,
   input  logic             clr_pos,
   input  logic             clr_fault,
   output logic [POS_W-1:0] pos,
   output logic             step_pulse,
   output logic             dir_out,
   output logic             locked,
   output logic             fault,
   output logic [1:0]       err_code,
   output logic             stall,
   output logic [1:0]       state_dbg
);

   localparam int CNT_W = $clog2(FILT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYC);

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      TRACK   = 2'd1,
      FAULT   = 2'd2
   } state_t;

   logic [3:0]       sync1, ph_s, cand, cand_nx, acc, last;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             acc_new;
   logic [3:0]       fwd_pat, bwd_pat, skip_pat;
   logic             is_idle, is_onehot;
   state_t           state, state_nx;
   logic [1:0]       err_nx;
   logic             step_fwd, step_bwd, last_load;

   // The sample that reloads cand counts as the first of the FILT_CYC identical ones.
   always_comb begin
      cand_nx = cand;
      cnt_nx  = cnt;
      if (ph_s != cand) begin
         cand_nx = ph_s;
         cnt_nx  = CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
         cnt_nx = cnt + CNT_W'(1);
      end
   end

   assign acc_new = (cnt_nx == CNT_MAX) && (cand_nx != acc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         ph_s  <= '0;
         cand  <= '0;
         cnt   <= '0;
         acc   <= '0;
      end else begin
         sync1 <= phase_in;
         ph_s  <= sync1;
         cand  <= cand_nx;
         cnt   <= cnt_nx;
         if (acc_new) acc <= cand_nx;
      end
   end

   assign fwd_pat   = {last[2:0], last[3]};
   assign bwd_pat   = {last[0], last[3:1]};
   assign skip_pat  = {last[1:0], last[3:2]};
   assign is_idle   = (cand_nx == 4'b0000);
   assign is_onehot = $onehot(cand_nx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACQUIRE;
      else     state <= state_nx;
   end

   // A one-hot pattern equal to last (seen after an idle gap) is neither a step nor a fault.
   always_comb begin
      state_nx = state;
      err_nx   = err_code;
      step_fwd = 1'b0;
      step_bwd = 1'b0;
      case (state)
         ACQUIRE: begin
            if (acc_new && !is_idle) begin
               if (is_onehot) begin
                  state_nx = TRACK;
               end else begin
                  state_nx = FAULT;
                  err_nx   = 2'b10;
               end
            end
         end
         TRACK: begin
            if (acc_new && !is_idle) begin
               if (!is_onehot) begin
                  state_nx = FAULT;
                  err_nx   = 2'b10;
               end else if (cand_nx == fwd_pat) begin
                  step_fwd = 1'b1;
               end else if (cand_nx == bwd_pat) begin
                  step_bwd = 1'b1;
               end else if (cand_nx == skip_pat) begin
                  state_nx = FAULT;
                  err_nx   = 2'b01;
               end
            end
         end
         FAULT: begin
            if (clr_fault) begin
               state_nx = ACQUIRE;
               err_nx   = 2'b00;
            end
         end
         default: begin
            state_nx = ACQUIRE;
            err_nx   = 2'b00;
         end
      endcase
   end

   assign last_load = ((state == ACQUIRE) && (state_nx == TRACK)) || step_fwd || step_bwd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_code   <= 2'b00;
         last       <= '0;
         pos        <= '0;
         dir_out    <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         err_code   <= err_nx;
         step_pulse <= step_fwd | step_bwd;
         if (last_load) last <= cand_nx;
         if (step_fwd)      dir_out <= 1'b1;
         else if (step_bwd) dir_out <= 1'b0;
         if (clr_pos)       pos <= '0;
         else if (step_fwd) pos <= pos + POS_W'(1);
         else if (step_bwd) pos <= pos - POS_W'(1);
      end
   end

   always_comb begin
      locked    = (state == TRACK);
      fault     = (state == FAULT);
      state_dbg = state;
   end

`ifdef STALL_DETECT_EN
   localparam int STL_W = $clog2(STALL_CYC + 1);
   localparam logic [STL_W-1:0] STL_MAX = STL_W'(STALL_CYC);
   logic [STL_W-1:0] stall_cnt;

   // Cleared while outside TRACK, on entry to TRACK and on every step; saturates at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((state_nx != TRACK) || (state != TRACK) || step_fwd || step_bwd) begin
         stall_cnt <= '0;
      end else if (stall_cnt != STL_MAX) begin
         stall_cnt <= stall_cnt + STL_W'(1);
      end
   end

   assign stall = (stall_cnt == STL_MAX);
`else
   assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// tb_stepper_phase_decoder: directed coil patterns checked against a sliding-window behavioural model.
// Stall expectations follow STALL_DETECT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_stepper_phase_decoder;

   localparam int POS_W     = 16;
   localparam int FILT_CYC  = 4;
   localparam int STALL_CYC = 100;
   localparam int EW        = 23;

`ifdef STALL_DETECT_EN
   localparam logic STALL_ON = 1'b1;
`else
   localparam logic STALL_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       phase_in = 4'b0000;
   logic             clr_pos = 1'b0;
   logic             clr_fault = 1'b0;
   logic [POS_W-1:0] pos;
   logic             step_pulse, dir_out, locked, fault, stall;
   logic [1:0]       err_code, state_dbg;

   stepper_phase_decoder #(
      .POS_W(POS_W), .FILT_CYC(FILT_CYC), .STALL_CYC(STALL_CYC)
   ) dut (
      .clk(clk), .rst(rst), .phase_in(phase_in), .clr_pos(clr_pos), .clr_fault(clr_fault),
      .pos(pos), .step_pulse(step_pulse), .dir_out(dir_out), .locked(locked), .fault(fault),
      .err_code(err_code), .stall(stall), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int change_cyc = 0;
   int step_cnt = 0;
   bit check_lat = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: raw phase_in samples, a pattern counts once FILT_CYC consecutive samples
   // (two sampling edges old) agree; motion is the index difference of the one-hot bit mod 4.
   logic [EW-1:0] exp_q[$];
   logic [3:0]    hist[0:7];
   logic [3:0]    m_acc, m_last, m_p;
   int            m_mode, m_old, m_d, m_idle;
   logic [15:0]   m_pos;
   logic          m_dir, m_step, m_stall, m_win;
   logic [1:0]    m_err;
   logic [EW-1:0] m_vec;

   function automatic int bit_idx(input logic [3:0] p);
      int r = 0;
      for (int i = 0; i < 4; i++) if (p[i]) r = i;
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) hist[i] = 4'b0000;
         m_acc = 4'b0000; m_last = 4'b0000; m_mode = 0; m_pos = 16'h0000;
         m_dir = 1'b0; m_step = 1'b0; m_err = 2'b00; m_idle = 0; m_stall = 1'b0;
         exp_q.delete();
      end else begin
         m_p = hist[1];
         m_win = 1'b1;
         for (int i = 2; i <= FILT_CYC; i++) if (hist[i] != m_p) m_win = 1'b0;
         m_old = m_mode;
         m_step = 1'b0;
         if (m_old == 2) begin
            if (clr_fault) begin m_mode = 0; m_err = 2'b00; end
         end else if (m_win && (m_p != m_acc) && (m_p != 4'b0000)) begin
            if (!$onehot(m_p)) begin
               m_mode = 2; m_err = 2'b10;
            end else if (m_old == 0) begin
               m_last = m_p; m_mode = 1;
            end else begin
               m_d = (bit_idx(m_p) - bit_idx(m_last)) & 3;
               if (m_d == 1) begin
                  m_pos = m_pos + 16'd1; m_dir = 1'b1; m_step = 1'b1; m_last = m_p;
               end else if (m_d == 3) begin
                  m_pos = m_pos - 16'd1; m_dir = 1'b0; m_step = 1'b1; m_last = m_p;
               end else if (m_d == 2) begin
                  m_mode = 2; m_err = 2'b01;
               end
            end
         end
         if (m_win) m_acc = m_p;
         if (clr_pos) m_pos = 16'h0000;
         if (m_mode == 1) begin
            if (m_old != 1 || m_step) m_idle = 0;
            else if (m_idle < STALL_CYC) m_idle++;
         end else begin
            m_idle = 0;
         end
         m_stall = STALL_ON && (m_idle == STALL_CYC);
         for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = phase_in;
         m_vec = {m_pos, m_step, m_dir, (m_mode == 1), (m_mode == 2), m_err, m_stall};
         exp_q.push_back(m_vec);
      end
   end

   logic [EW-1:0] got_vec, exp_vec;
   assign got_vec = {pos, step_pulse, dir_out, locked, fault, err_code, stall};

   always @(negedge clk) begin
      if (rst) begin
         check("reset_outputs", 32'(got_vec), 32'(0));
      end else if (exp_q.size() > 0) begin
         exp_vec = exp_q.pop_front();
         check("model_outputs", 32'(got_vec), 32'(exp_vec));
      end
      if (!rst && step_pulse) begin
         step_cnt++;
         if (check_lat) check("step_latency", 32'(cyc - change_cyc), 32'(5));
      end
   end

   // Drivers: every task starts and ends 1 time unit after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [3:0] p, input int n);
      phase_in = p;
      change_cyc = cyc + 1;
      tick(n);
   endtask

   task automatic do_reset();
      rst = 1'b1; phase_in = 4'b0000; clr_pos = 1'b0; clr_fault = 1'b0;
      tick(3);
      rst = 1'b0;
   endtask

   initial begin
      tick(1);
      do_reset();

      // Forward sequence with latency checks.
      step_cnt = 0;
      check_lat = 1'b1;
      hold(4'b0001, 10);
      check("t1_locked", 32'(locked), 32'(1));
      check("t1_no_step", 32'(pos), 32'(0));
      hold(4'b0010, 10); hold(4'b0100, 10); hold(4'b1000, 10); hold(4'b0001, 10);
      check_lat = 1'b0;
      check("t1_steps", 32'(step_cnt), 32'(4));
      check("t1_pos", 32'(pos), 32'(4));
      check("t1_dir", 32'(dir_out), 32'(1));

      // Reverse with wrap, idle gap, then resume relative to the retained phase.
      do_reset();
      hold(4'b0001, 10); hold(4'b1000, 10); hold(4'b0100, 10);
      check("t2_pos_wrap", 32'(pos), 32'(16'hFFFE));
      check("t2_dir", 32'(dir_out), 32'(0));
      hold(4'b0000, 20); hold(4'b0010, 10);
      check("t2_pos_resume", 32'(pos), 32'(16'hFFFD));
      check("t2_no_fault", 32'(fault), 32'(0));
      clr_fault = 1'b1; tick(1); clr_fault = 1'b0; tick(2);
      check("t2_clr_fault_ignored", 32'(locked), 32'(1));

      // Glitches shorter than the filter window.
      do_reset();
      hold(4'b0001, 10);
      step_cnt = 0;
      hold(4'b0010, 3); hold(4'b0001, 10);
      check("t3_glitch_steps", 32'(step_cnt), 32'(0));
      check("t3_glitch_pos", 32'(pos), 32'(0));
      hold(4'b1100, 2); hold(4'b0001, 10);
      check("t3_multi_glitch", 32'(fault), 32'(0));

      // Skip fault, frozen position, recovery, multi-hot fault.
      do_reset();
      hold(4'b0001, 10); hold(4'b0100, 10);
      check("t4_fault", 32'(fault), 32'(1));
      check("t4_err_skip", 32'(err_code), 32'(2'b01));
      check("t4_unlocked", 32'(locked), 32'(0));
      hold(4'b1000, 10); hold(4'b0001, 10); hold(4'b0010, 10);
      check("t4_pos_frozen", 32'(pos), 32'(0));
      clr_fault = 1'b1; tick(1); clr_fault = 1'b0; tick(2);
      check("t4_recovered", 32'(fault), 32'(0));
      check("t4_err_clear", 32'(err_code), 32'(2'b00));
      hold(4'b0011, 10);
      check("t4_err_multi", 32'(err_code), 32'(2'b10));

      // clr_pos colliding with a forward step from 7.
      do_reset();
      hold(4'b0001, 10);
      hold(4'b0010, 10); hold(4'b0100, 10); hold(4'b1000, 10); hold(4'b0001, 10);
      hold(4'b0010, 10); hold(4'b0100, 10); hold(4'b1000, 10);
      check("t5_pos7", 32'(pos), 32'(7));
      hold(4'b0001, 5);
      clr_pos = 1'b1; tick(1);
      check("t5_step", 32'(step_pulse), 32'(1));
      check("t5_pos_cleared", 32'(pos), 32'(0));
      check("t5_dir", 32'(dir_out), 32'(1));
      clr_pos = 1'b0; tick(8);

      // Stall window and release on the next step.
      do_reset();
      hold(4'b0001, 120);
      check("t6_stall", 32'(stall), 32'(STALL_ON));
      hold(4'b0010, 5);
      check("t6_stall_held", 32'(stall), 32'(STALL_ON));
      tick(1);
      check("t6_step", 32'(step_pulse), 32'(1));
      check("t6_stall_release", 32'(stall), 32'(0));
      tick(5);

      // Reset in the middle of a partial filter count.
      do_reset();
      hold(4'b0001, 10);
      step_cnt = 0;
      hold(4'b0010, 2);
      do_reset();
      hold(4'b0010, 10);
      check("t7_relock", 32'(locked), 32'(1));
      check("t7_pos", 32'(pos), 32'(0));
      check("t7_no_step", 32'(step_cnt), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
